// File: rtl/pdm_pkg.sv
// Shared types and defaults for the PDM capture path.
package pdm_pkg;

    localparam int PCM_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAKEUP,
        DISCARD,
        CAPTURE,
        DRAIN
    } pdm_ctrl_state_t;

endpackage

// File: rtl/pdm_capture_ctrl_fifo.sv
// Show-ahead sample FIFO: the head entry is visible on rdata whenever not empty.
module pdm_sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    // Zero while empty so the stream data reads 0 out of reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// Capture sequencer: wake the mic, drop settling samples, frame PCM into a FIFO stream.
module pdm_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int DATA_WIDTH      = PCM_WIDTH,
    parameter int WAKEUP_CYCLES   = 1_000_000,
    parameter int DISCARD_SAMPLES = 64,
    parameter int FRAME_LEN       = 1024,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    output logic                  cap_en,
    input  logic [DATA_WIDTH-1:0] pcm_in,
    input  logic                  pcm_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  overflow
);

    localparam int WW = $clog2(WAKEUP_CYCLES + 1);
    localparam int DW = (DISCARD_SAMPLES > 0) ? $clog2(DISCARD_SAMPLES + 1) : 1;
    localparam int SW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKEUP_CYCLES - 1);
    localparam logic [DW-1:0] DISC_LAST = DW'((DISCARD_SAMPLES > 0) ? DISCARD_SAMPLES - 1 : 0);
    localparam logic [SW-1:0] SMP_LAST  = SW'(FRAME_LEN - 1);

    pdm_ctrl_state_t state;
    logic [WW-1:0]   wake_cnt;
    logic [DW-1:0]   disc_cnt;
    logic [SW-1:0]   smp_cnt;
    logic            stop_pend;

    logic            f_push;
    logic            f_pop;
    logic            f_full;
    logic            f_empty;
    logic [CW-1:0]   f_count;
    logic            smp_in;
    logic            drop;
    logic            frame_end;
    logic            drain_done;
    logic            keep_going;

    assign m_valid    = !f_empty;
    assign f_pop      = m_valid && m_ready;
    assign smp_in     = (state == CAPTURE) && pcm_valid;
    assign f_push     = smp_in && (!f_full || f_pop);
    assign drop       = smp_in && !f_push;
    assign frame_end  = smp_in && (smp_cnt == SMP_LAST);
    // Leave DRAIN on the same edge that pops the last entry, so m_valid and busy fall together.
    assign drain_done = f_empty || ((f_count == CW'(1)) && f_pop);
    assign keep_going = continuous && !stop_pend && !stop;
    assign busy       = (state != IDLE);

    pdm_sample_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (f_push),
        .wdata ({frame_end, pcm_in}),
        .pop   (f_pop),
        .rdata ({m_last, m_data}),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_en    <= 1'b0;
            wake_cnt  <= '0;
            disc_cnt  <= '0;
            smp_cnt   <= '0;
            stop_pend <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAKEUP;
                        cap_en    <= 1'b1;
                        wake_cnt  <= '0;
                        disc_cnt  <= '0;
                        smp_cnt   <= '0;
                        stop_pend <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                WAKEUP: begin
                    if (stop) begin
                        state  <= IDLE;
                        cap_en <= 1'b0;
                    end else if (wake_cnt == WAKE_LAST) begin
                        state <= (DISCARD_SAMPLES == 0) ? CAPTURE : DISCARD;
                    end else begin
                        wake_cnt <= wake_cnt + WW'(1);
                    end
                end
                DISCARD: begin
                    if (stop) begin
                        state  <= IDLE;
                        cap_en <= 1'b0;
                    end else if (pcm_valid) begin
                        if (disc_cnt == DISC_LAST)
                            state <= CAPTURE;
                        else
                            disc_cnt <= disc_cnt + DW'(1);
                    end
                end
                CAPTURE: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (drop)
                        overflow <= 1'b1;
                    // Counter advances on dropped samples too, keeping frames aligned to time.
                    if (smp_in) begin
                        smp_cnt <= frame_end ? '0 : smp_cnt + SW'(1);
                        if (frame_end && !keep_going) begin
                            state  <= DRAIN;
                            cap_en <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done)
                        state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    cap_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with a 1-in-5 ramp sample source.
module tb_pdm_capture_ctrl;
    import pdm_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          continuous = 1'b0;
    logic          pcm_valid = 1'b0;
    logic [DW-1:0] pcm_in = '0;
    logic          m_ready = 1'b1;
    logic          cap_en;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic          busy;
    logic          overflow;

    int            n_checks = 0;
    int            n_fail = 0;
    int            gen_t = 0;
    int            gen_val = 1;
    bit            gen_on = 1'b0;
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];

    pdm_capture_ctrl #(
        .DATA_WIDTH      (DW),
        .WAKEUP_CYCLES   (10),
        .DISCARD_SAMPLES (4),
        .FRAME_LEN       (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .cap_en     (cap_en),
        .pcm_in     (pcm_in),
        .pcm_valid  (pcm_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: record a pop, drive the ramp source, then land 1 ns after the edge.
    task automatic tick();
        @(negedge clk);
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
        end
        pcm_valid = 1'b0;
        if (gen_on) begin
            gen_t++;
            if (gen_t % 5 == 0) begin
                pcm_valid = 1'b1;
                pcm_in    = DW'(gen_val);
                gen_val++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gen(input int n);
        while (gen_t < n) tick();
    endtask

    task automatic begin_source();
        gen_t   = 0;
        gen_val = 1;
        gen_on  = 1'b1;
        got_d.delete();
        got_l.delete();
    endtask

    task automatic start_wake(input logic with_stop);
        gen_on = 1'b0;
        start  = 1'b1;
        stop   = with_stop;
        tick();
        start  = 1'b0;
        stop   = 1'b0;
        repeat (10) tick();
        begin_source();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cap_en, m_valid, m_last, busy, overflow, m_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cap_en=%b m_valid=%b m_last=%b busy=%b overflow=%b m_data=%0d, required all 0",
                     cap_en, m_valid, m_last, busy, overflow, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || cap_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stop_ignored: busy=%b cap_en=%b, required 0 0", busy, cap_en);
        end
    endtask

    task automatic test_single_frame();
        bit bad;
        continuous = 1'b0;
        m_ready    = 1'b1;
        gen_on     = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        n_checks++;
        if (dut.state !== WAKEUP || cap_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL s1_start: state=%0d cap_en=%b busy=%b, required WAKEUP 1 1", dut.state, cap_en, busy);
        end
        repeat (9) tick();
        n_checks++;
        if (dut.state !== WAKEUP || cap_en !== 1'b1) begin
            n_fail++;
            $display("FAIL s1_wake_len9: state=%0d cap_en=%b, required WAKEUP 1", dut.state, cap_en);
        end
        tick();
        n_checks++;
        if (dut.state !== DISCARD || cap_en !== 1'b1) begin
            n_fail++;
            $display("FAIL s1_wake_len10: state=%0d cap_en=%b, required DISCARD 1", dut.state, cap_en);
        end
        begin_source();
        wait_gen(20);
        n_checks++;
        if (dut.state !== CAPTURE || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL s1_discard: state=%0d m_valid=%b, required CAPTURE 0", dut.state, m_valid);
        end
        wait_gen(25);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== DW'(5) || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL s1_latency: m_valid=%b m_data=%0d m_last=%b, required 1 5 0", m_valid, m_data, m_last);
        end
        wait_gen(60);
        n_checks++;
        if (dut.state !== DRAIN || cap_en !== 1'b0 || m_data !== DW'(12) || m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL s1_frame_end: state=%0d cap_en=%b m_data=%0d m_last=%b, required DRAIN 0 12 1",
                     dut.state, cap_en, m_data, m_last);
        end
        tick();
        n_checks++;
        if (dut.state !== IDLE || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL s1_idle: state=%0d busy=%b m_valid=%b, required IDLE 0 0", dut.state, busy, m_valid);
        end
        exp_d.delete();
        exp_l.delete();
        for (int v = 5; v <= 12; v++) begin
            exp_d.push_back(DW'(v));
            exp_l.push_back(v == 12);
        end
        n_checks++;
        bad = (got_d.size() != exp_d.size());
        for (int i = 0; i < got_d.size() && !bad; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad = 1'b1;
        if (bad) begin
            n_fail++;
            $display("FAIL s1_stream: got %0d samples, required %0d (5..12, last on 12)", got_d.size(), exp_d.size());
        end
    endtask

    task automatic test_continuous_stop();
        bit bad;
        continuous = 1'b1;
        m_ready    = 1'b1;
        start_wake(1'b0);
        wait_gen(75);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_gen(100);
        n_checks++;
        if (dut.state !== DRAIN || cap_en !== 1'b0) begin
            n_fail++;
            $display("FAIL s2_drain: state=%0d cap_en=%b, required DRAIN 0", dut.state, cap_en);
        end
        wait_gen(110);
        n_checks++;
        if (dut.state !== IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL s2_idle: state=%0d busy=%b, required IDLE 0", dut.state, busy);
        end
        exp_d.delete();
        exp_l.delete();
        for (int v = 5; v <= 20; v++) begin
            exp_d.push_back(DW'(v));
            exp_l.push_back(v == 12 || v == 20);
        end
        n_checks++;
        bad = (got_d.size() != exp_d.size());
        for (int i = 0; i < got_d.size() && !bad; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad = 1'b1;
        if (bad) begin
            n_fail++;
            $display("FAIL s2_stream: got %0d samples, required %0d (5..20, last on 12 and 20)", got_d.size(), exp_d.size());
        end
        continuous = 1'b0;
    endtask

    task automatic test_backpressure();
        bit bad;
        continuous = 1'b1;
        m_ready    = 1'b1;
        start_wake(1'b0);
        wait_gen(20);
        m_ready = 1'b0;
        wait_gen(40);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== DW'(5) || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL s3_full: m_valid=%b m_data=%0d overflow=%b, required 1 5 0", m_valid, m_data, overflow);
        end
        wait_gen(60);
        n_checks++;
        if (overflow !== 1'b1 || m_data !== DW'(5)) begin
            n_fail++;
            $display("FAIL s3_overflow: overflow=%b m_data=%0d, required 1 5", overflow, m_data);
        end
        m_ready = 1'b1;
        wait_gen(66);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_gen(101);
        n_checks++;
        if (dut.state !== IDLE || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL s3_idle: state=%0d overflow=%b, required IDLE 1", dut.state, overflow);
        end
        exp_d.delete();
        exp_l.delete();
        for (int v = 5; v <= 8; v++) begin
            exp_d.push_back(DW'(v));
            exp_l.push_back(1'b0);
        end
        for (int v = 13; v <= 20; v++) begin
            exp_d.push_back(DW'(v));
            exp_l.push_back(v == 20);
        end
        n_checks++;
        bad = (got_d.size() != exp_d.size());
        for (int i = 0; i < got_d.size() && !bad; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad = 1'b1;
        if (bad) begin
            n_fail++;
            $display("FAIL s3_stream: got %0d samples, required %0d (5..8, 13..20, last on 20)", got_d.size(), exp_d.size());
        end
        gen_on = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || dut.state !== WAKEUP) begin
            n_fail++;
            $display("FAIL s3_ovf_clear: overflow=%b state=%0d, required 0 WAKEUP", overflow, dut.state);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        continuous = 1'b0;
    endtask

    task automatic test_full_with_pop();
        bit bad;
        continuous = 1'b0;
        m_ready    = 1'b1;
        start_wake(1'b0);
        wait_gen(20);
        m_ready = 1'b0;
        wait_gen(44);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== DW'(5) || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL s4_stall_stable: m_valid=%b m_data=%0d m_last=%b, required 1 5 0", m_valid, m_data, m_last);
        end
        m_ready = 1'b1;
        wait_gen(45);
        n_checks++;
        if (overflow !== 1'b0 || m_data !== DW'(6)) begin
            n_fail++;
            $display("FAIL s4_push_pop: overflow=%b m_data=%0d, required 0 6", overflow, m_data);
        end
        wait_gen(61);
        exp_d.delete();
        exp_l.delete();
        for (int v = 5; v <= 12; v++) begin
            exp_d.push_back(DW'(v));
            exp_l.push_back(v == 12);
        end
        n_checks++;
        bad = (got_d.size() != exp_d.size()) || (overflow !== 1'b0) || (dut.state !== IDLE);
        for (int i = 0; i < got_d.size() && !bad; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad = 1'b1;
        if (bad) begin
            n_fail++;
            $display("FAIL s4_stream: got %0d samples overflow=%b state=%0d, required 8 (5..12) 0 IDLE",
                     got_d.size(), overflow, dut.state);
        end
    endtask

    task automatic test_stop_wakeup();
        gen_on = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (dut.state !== IDLE || cap_en !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL s5_stop_wake: state=%0d cap_en=%b busy=%b m_valid=%b, required IDLE 0 0 0",
                     dut.state, cap_en, busy, m_valid);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (dut.state !== WAKEUP || cap_en !== 1'b1) begin
            n_fail++;
            $display("FAIL s5_start_wins: state=%0d cap_en=%b, required WAKEUP 1", dut.state, cap_en);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        continuous = 1'b0;
        m_ready    = 1'b1;
        start_wake(1'b0);
        wait_gen(20);
        m_ready = 1'b0;
        wait_gen(36);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== DW'(5) || dut.state !== CAPTURE) begin
            n_fail++;
            $display("FAIL s6_queued: m_valid=%b m_data=%0d state=%0d, required 1 5 CAPTURE", m_valid, m_data, dut.state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cap_en, m_valid, m_last, busy, overflow, m_data} !== '0 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL s6_async_reset: cap_en=%b m_valid=%b m_last=%b busy=%b m_data=%0d, required all 0",
                     cap_en, m_valid, m_last, busy, m_data);
        end
        gen_on = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();
        test_single_frame();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous_stop();
        test_backpressure();
        test_full_with_pop();
        test_stop_wakeup();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
